// File: rtl/alu_pkg.sv
// Shared ALU types: logic-unit op encoding and the multi-word logic sequencer states.
package alu_pkg;

  typedef enum logic [1:0] {
    LOP_NOTB = 2'd0,
    LOP_AND  = 2'd1,
    LOP_OR   = 2'd2,
    LOP_XOR  = 2'd3
  } logic_op_e;

  typedef enum logic [1:0] {
    LS_IDLE = 2'd0,
    LS_RUN  = 2'd1,
    LS_DONE = 2'd2
  } logic_seq_state_e;

endpackage

// File: rtl/logic_seq_if.sv
// Request, response and logic-unit signals of logic_seq; the slave modport is the sequencer's view.
// Optional rsp_parity_o is present when LOGIC_SEQ_PARITY_EN is defined.
interface logic_seq_if #(
  parameter int WORD_WIDTH = 16,
  parameter int WORDS      = 4
);
  localparam int OP_W = WORDS * WORD_WIDTH;

  logic                  req_valid_i;
  logic                  req_ready_o;
  logic [1:0]            req_op_i;
  logic [OP_W-1:0]       req_a_i;
  logic [OP_W-1:0]       req_b_i;
  logic [1:0]            lu_op_o;
  logic [WORD_WIDTH-1:0] lu_a_o;
  logic [WORD_WIDTH-1:0] lu_b_o;
  logic [WORD_WIDTH-1:0] lu_not_b_o;
  logic [WORD_WIDTH-1:0] lu_r_i;
  logic                  rsp_valid_o;
  logic                  rsp_ready_i;
  logic [OP_W-1:0]       rsp_r_o;
  logic                  rsp_zero_o;
`ifdef LOGIC_SEQ_PARITY_EN
  logic                  rsp_parity_o;
`endif

  modport slave (
    input  req_valid_i, req_op_i, req_a_i, req_b_i, lu_r_i, rsp_ready_i,
    output
`ifdef LOGIC_SEQ_PARITY_EN
           rsp_parity_o,
`endif
           req_ready_o, lu_op_o, lu_a_o, lu_b_o, lu_not_b_o,
           rsp_valid_o, rsp_r_o, rsp_zero_o
  );

  modport master (
    output req_valid_i, req_op_i, req_a_i, req_b_i, lu_r_i, rsp_ready_i,
    input
`ifdef LOGIC_SEQ_PARITY_EN
           rsp_parity_o,
`endif
           req_ready_o, lu_op_o, lu_a_o, lu_b_o, lu_not_b_o,
           rsp_valid_o, rsp_r_o, rsp_zero_o
  );

endinterface

// File: rtl/logic_seq.sv
// Multi-word initiator for the single-word logic unit: walks operand slices LS word first and assembles the result.
// Optional LOGIC_SEQ_PARITY_EN adds rsp_parity_o, the XOR-reduction of the registered result.
module logic_seq
  import alu_pkg::*;
#(
  parameter int WORD_WIDTH = 16,
  parameter int WORDS      = 4
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  logic_seq_if.slave  bus
);

  localparam int OP_W  = WORDS * WORD_WIDTH;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  logic_seq_state_e      state_r, state_nxt_s;
  logic_op_e             op_r, op_nxt_s;
  logic [OP_W-1:0]       a_r, a_nxt_s, b_r, b_nxt_s;
  logic [OP_W-1:0]       result_r, result_nxt_s, rsp_r_r, rsp_r_nxt_s;
  logic [IDX_W-1:0]      idx_r, idx_nxt_s;
  logic                  zero_r, zero_nxt_s;
  logic                  ready_r, ready_nxt_s, valid_r, valid_nxt_s;
  logic [1:0]            lu_op_r, lu_op_nxt_s;
  logic [WORD_WIDTH-1:0] lu_a_r, lu_a_nxt_s, lu_b_r, lu_b_nxt_s, lu_not_b_r, lu_not_b_nxt_s;
  logic                  req_fire_s, rsp_fire_s, last_s;

  assign req_fire_s = ready_r & bus.req_valid_i;
  assign rsp_fire_s = valid_r & bus.rsp_ready_i;
  assign last_s     = (idx_r == LAST_IDX);

  // State register
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_r <= LS_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      LS_IDLE: if (req_fire_s) state_nxt_s = LS_RUN;  else state_nxt_s = LS_IDLE;
      LS_RUN:  if (last_s)     state_nxt_s = LS_DONE; else state_nxt_s = LS_RUN;
      LS_DONE: if (rsp_fire_s) state_nxt_s = LS_IDLE; else state_nxt_s = LS_DONE;
      default: state_nxt_s = LS_IDLE;
    endcase
  end

  // Operand latch, slice index and result assembly
  always_comb begin
    op_nxt_s     = op_r;
    a_nxt_s      = a_r;
    b_nxt_s      = b_r;
    idx_nxt_s    = idx_r;
    result_nxt_s = result_r;
    rsp_r_nxt_s  = rsp_r_r;
    zero_nxt_s   = zero_r;
    case (state_r)
      LS_IDLE: begin
        if (req_fire_s) begin
          op_nxt_s  = logic_op_e'(bus.req_op_i);
          a_nxt_s   = bus.req_a_i;
          b_nxt_s   = bus.req_b_i;
          idx_nxt_s = '0;
        end else begin
          idx_nxt_s = idx_r;
        end
      end
      LS_RUN: begin
        result_nxt_s[int'(idx_r) * WORD_WIDTH +: WORD_WIDTH] = bus.lu_r_i;
        if (last_s) begin
          idx_nxt_s   = '0;
          rsp_r_nxt_s = result_nxt_s;
          zero_nxt_s  = (result_nxt_s == '0);
        end else begin
          idx_nxt_s = idx_r + IDX_W'(1);
        end
      end
      LS_DONE: idx_nxt_s = idx_r;
      default: idx_nxt_s = '0;
    endcase
  end

  // Output next values; lu_* are pre-loaded with the slice the next RUN cycle needs
  always_comb begin
    ready_nxt_s    = (state_nxt_s == LS_IDLE);
    valid_nxt_s    = (state_nxt_s == LS_DONE);
    lu_op_nxt_s    = 2'd0;
    lu_a_nxt_s     = '0;
    lu_b_nxt_s     = '0;
    lu_not_b_nxt_s = '0;
    if (state_nxt_s == LS_RUN) begin
      lu_op_nxt_s    = op_nxt_s;
      lu_a_nxt_s     = a_nxt_s[int'(idx_nxt_s) * WORD_WIDTH +: WORD_WIDTH];
      lu_b_nxt_s     = b_nxt_s[int'(idx_nxt_s) * WORD_WIDTH +: WORD_WIDTH];
      lu_not_b_nxt_s = ~b_nxt_s[int'(idx_nxt_s) * WORD_WIDTH +: WORD_WIDTH];
    end else begin
      lu_op_nxt_s = 2'd0;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      op_r       <= LOP_NOTB;
      a_r        <= '0;
      b_r        <= '0;
      idx_r      <= '0;
      result_r   <= '0;
      rsp_r_r    <= '0;
      zero_r     <= 1'b0;
      ready_r    <= 1'b0;
      valid_r    <= 1'b0;
      lu_op_r    <= 2'd0;
      lu_a_r     <= '0;
      lu_b_r     <= '0;
      lu_not_b_r <= '0;
    end else begin
      op_r       <= op_nxt_s;
      a_r        <= a_nxt_s;
      b_r        <= b_nxt_s;
      idx_r      <= idx_nxt_s;
      result_r   <= result_nxt_s;
      rsp_r_r    <= rsp_r_nxt_s;
      zero_r     <= zero_nxt_s;
      ready_r    <= ready_nxt_s;
      valid_r    <= valid_nxt_s;
      lu_op_r    <= lu_op_nxt_s;
      lu_a_r     <= lu_a_nxt_s;
      lu_b_r     <= lu_b_nxt_s;
      lu_not_b_r <= lu_not_b_nxt_s;
    end
  end

`ifdef LOGIC_SEQ_PARITY_EN
  function automatic logic parity_f(input logic [OP_W-1:0] v);
    return ^v;
  endfunction

  logic parity_r;

  // Parity follows the result register, so it is held with the response
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      parity_r <= 1'b0;
    end else if ((state_r == LS_RUN) && last_s) begin
      parity_r <= parity_f(result_nxt_s);
    end else begin
      parity_r <= parity_r;
    end
  end

  assign bus.rsp_parity_o = parity_r;
`endif

  assign bus.req_ready_o = ready_r;
  assign bus.rsp_valid_o = valid_r;
  assign bus.rsp_r_o     = rsp_r_r;
  assign bus.rsp_zero_o  = zero_r;
  assign bus.lu_op_o     = lu_op_r;
  assign bus.lu_a_o      = lu_a_r;
  assign bus.lu_b_o      = lu_b_r;
  assign bus.lu_not_b_o  = lu_not_b_r;

endmodule

// File: tb/tb_logic_seq.sv
// Bench for logic_seq (WORD_WIDTH=8, WORDS=4): directed and random requests checked against a whole-word model.
module tb_logic_seq;

  localparam int W = 8;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   acc1, acc2;

  always #5 clk = ~clk;

  // Free-running cycle count used to measure accept-to-accept spacing
  always @(posedge clk) cyc <= cyc + 1;

  logic_seq_if #(.WORD_WIDTH(W), .WORDS(N)) bus ();

  logic_seq #(.WORD_WIDTH(W), .WORDS(N)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  // Behavioural single-word logic unit
  always_comb begin
    bus.lu_r_i = '0;
    case (bus.lu_op_o)
      2'd0:    bus.lu_r_i = bus.lu_not_b_o;
      2'd1:    bus.lu_r_i = bus.lu_a_o & bus.lu_b_o;
      2'd2:    bus.lu_r_i = bus.lu_a_o | bus.lu_b_o;
      2'd3:    bus.lu_r_i = bus.lu_a_o ^ bus.lu_b_o;
      default: bus.lu_r_i = '0;
    endcase
  end

  function automatic logic [31:0] ref_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      2'd0:    return ~b;
      2'd1:    return a & b;
      2'd2:    return a | b;
      default: return a ^ b;
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_valid"}, 64'(bus.rsp_valid_o), 64'(0));
    check({tag, "_lu_op"}, 64'(bus.lu_op_o), 64'(0));
    check({tag, "_lu_a"}, 64'(bus.lu_a_o), 64'(0));
    check({tag, "_lu_b"}, 64'(bus.lu_b_o), 64'(0));
    check({tag, "_lu_notb"}, 64'(bus.lu_not_b_o), 64'(0));
  endtask

  // Waits (bounded) for ready, presents the request for one edge; returns at the negedge after acceptance
  task automatic accept(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, output int acc_cyc);
    int waited = 0;
    while (bus.req_ready_o !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("req_ready_before_accept", 64'(bus.req_ready_o), 64'(1));
    bus.req_valid_i = 1'b1;
    bus.req_op_i    = op;
    bus.req_a_i     = a;
    bus.req_b_i     = b;
    @(posedge clk);
    #1 acc_cyc = cyc;
    @(negedge clk);
    bus.req_valid_i = 1'b0;
  endtask

  // Full transaction: slice sequence, exact latency, held response for `hold` cycles, return to idle
  task automatic run_txn(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int hold, output int acc_cyc);
    logic [31:0] exp;
    exp = ref_op(op, a, b);
    bus.rsp_ready_i = 1'b0;
    accept(op, a, b, acc_cyc);
    for (int k = 0; k < N; k++) begin
      check("lu_op", 64'(bus.lu_op_o), 64'(op));
      check("lu_a", 64'(bus.lu_a_o), 64'((a >> (W * k)) & 32'hFF));
      check("lu_b", 64'(bus.lu_b_o), 64'((b >> (W * k)) & 32'hFF));
      check("lu_not_b", 64'(bus.lu_not_b_o), 64'((~b >> (W * k)) & 32'hFF));
      check("run_req_ready", 64'(bus.req_ready_o), 64'(0));
      check("run_rsp_valid", 64'(bus.rsp_valid_o), 64'(0));
      bus.req_a_i  = $urandom();
      bus.req_b_i  = $urandom();
      bus.req_op_i = 2'($urandom_range(0, 3));
      @(negedge clk);
    end
    check("rsp_valid_latency", 64'(bus.rsp_valid_o), 64'(1));
    check("rsp_r", 64'(bus.rsp_r_o), 64'(exp));
    check("rsp_zero", 64'(bus.rsp_zero_o), 64'(exp == 32'd0));
`ifdef LOGIC_SEQ_PARITY_EN
    check("rsp_parity", 64'(bus.rsp_parity_o), 64'($countones(exp) % 2));
`endif
    for (int h = 1; h <= hold; h++) begin
      @(negedge clk);
      check("hold_valid", 64'(bus.rsp_valid_o), 64'(1));
      check("hold_r", 64'(bus.rsp_r_o), 64'(exp));
      check("hold_req_ready", 64'(bus.req_ready_o), 64'(0));
    end
    bus.rsp_ready_i = 1'b1;
    @(negedge clk);
    bus.rsp_ready_i = 1'b0;
    check("post_rsp_valid", 64'(bus.rsp_valid_o), 64'(0));
    check("post_req_ready", 64'(bus.req_ready_o), 64'(1));
  endtask

  initial begin
    bus.req_valid_i = 1'b0;
    bus.req_op_i    = 2'd0;
    bus.req_a_i     = '0;
    bus.req_b_i     = '0;
    bus.rsp_ready_i = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    check("reset_req_ready", 64'(bus.req_ready_o), 64'(0));
    check("reset_rsp_r", 64'(bus.rsp_r_o), 64'(0));
    check("reset_zero", 64'(bus.rsp_zero_o), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);
    check("release_req_ready", 64'(bus.req_ready_o), 64'(1));

    run_txn(2'd3, 32'hFF00F0F0, 32'h0FF0FF00, 0, acc1);
    run_txn(2'd1, 32'h12345678, 32'hFFFF0000, 0, acc1);
    run_txn(2'd0, 32'hA5A5A5A5, 32'hFFFFFFFF, 0, acc1);
    run_txn(2'd2, 32'h0000000F, 32'h000000F0, 3, acc1);

    // Reset during the second RUN cycle aborts the operation
    accept(2'd3, 32'hDEADBEEF, 32'h01234567, acc1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_idle_outputs("abort");
    check("abort_rsp_r", 64'(bus.rsp_r_o), 64'(0));
    check("abort_req_ready", 64'(bus.req_ready_o), 64'(0));
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_no_rsp", 64'(bus.rsp_valid_o), 64'(0));
    end
    run_txn(2'd3, 32'hCAFEF00D, 32'h0F0F0F0F, 0, acc1);

    // Back-to-back with operands scrambled mid-RUN inside run_txn
    run_txn(2'd1, 32'h89ABCDEF, 32'hF0F0F0F0, 0, acc1);
    run_txn(2'd2, 32'h00FF00FF, 32'h11001100, 0, acc2);
    check("b2b_spacing", 64'(acc2 - acc1), 64'(N + 2));

    for (int t = 0; t < 12; t++) begin
      logic [31:0] ra;
      ra = $urandom();
      run_txn(2'($urandom_range(0, 3)), ra, (t % 4 == 0) ? ra : 32'($urandom()),
              int'($urandom_range(0, 2)), acc1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/logic_seq.md
Name: logic_seq

Overview:
Multi-word initiator for the ALU logic unit. It accepts a wide logic request (op, a, b) over a valid/ready handshake. It then drives the WORD_WIDTH-wide logic-unit interface one word slice per cycle, LS word first, and assembles the result. The wide result is returned over a valid/ready response channel with a zero flag. It sits between the multi-word execute control and the single-word combinational logic unit.

Parameters:
WORD_WIDTH, 16, width of one logic-unit slice
WORDS, 4, number of slices per operand (>=1); operand width = WORDS*WORD_WIDTH

Ports:
clk_i  in  1  clock
rst_n_i  in  1  synchronous active-low reset
req_valid_i  in  1  request valid
req_ready_o  out  1  request ready
req_op_i  in  2  logic op (logic_op_e)
req_a_i  in  WORDS*WORD_WIDTH  operand A
req_b_i  in  WORDS*WORD_WIDTH  operand B
lu_op_o  out  2  op to logic unit
lu_a_o  out  WORD_WIDTH  A slice to logic unit
lu_b_o  out  WORD_WIDTH  B slice to logic unit
lu_not_b_o  out  WORD_WIDTH  ~B slice to logic unit
lu_r_i  in  WORD_WIDTH  combinational slice result from logic unit
rsp_valid_o  out  1  response valid
rsp_ready_i  in  1  response ready
rsp_r_o  out  WORDS*WORD_WIDTH  assembled result
rsp_zero_o  out  1  rsp_r_o == 0

Behaviour:
- One clock, clk_i. Reset rst_n_i is synchronous, active-low.
- Reset (rst_n_i low at a clk_i edge):
  - state=IDLE, idx=0, latched op/a/b=0, result=0.
  - rsp_valid_o=0, rsp_r_o=0, rsp_zero_o=0, lu_*=0.
  - req_ready_o is low while rst_n_i is low and 1 from the first cycle after release.
- Op encoding: 0 NOTB (r=~b), 1 AND, 2 OR, 3 XOR.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - req_ready_o=1.
  - On req_valid_i: latch op/a/b, idx=0, go to RUN.
- RUN:
  - req_ready_o=0.
  - Drive lu_op_o=op, lu_a_o=a[idx slice], lu_b_o=b[idx slice], lu_not_b_o=~b[idx slice].
  - Slice idx = bits [idx*WORD_WIDTH +: WORD_WIDTH].
  - Each edge: result[idx slice] <= lu_r_i.
  - If idx==WORDS-1, go to DONE; else idx+1.
- DONE:
  - rsp_valid_o=1. rsp_r_o and rsp_zero_o are registered and held stable until rsp_ready_i.
  - On rsp_valid_o&&rsp_ready_i: go to IDLE and drop rsp_valid_o next cycle.
  - A new request is not accepted in the same cycle (req_ready_o=0 in DONE).
- Latency: handshake edge at cycle 0; RUN occupies cycles 1..WORDS; rsp_valid_o is high from cycle WORDS+1.
- Throughput: one request per WORDS+2 cycles when rsp_ready_i is held high.
- lu_* outputs are 0 outside RUN.
- The block ignores req_* changes after acceptance (operands are latched).
- WORDS=1: RUN lasts exactly one cycle.
- Reset in RUN or DONE aborts the operation. No response is issued and the partial result is cleared.
- rsp_zero_o is computed from the fully assembled result at entry to DONE.
- No error conditions; all op values are legal.

Optional Feature:
LOGIC_SEQ_PARITY_EN:
- Defined: adds output rsp_parity_o (1 bit) = XOR-reduction of rsp_r_o.
  - Registered with rsp_r_o; reset 0; held stable with the response.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package alu_pkg holds:
  - typedef enum logic [1:0] logic_op_e {LOP_NOTB=0, LOP_AND=1, LOP_OR=2, LOP_XOR=3}
  - typedef enum logic [1:0] logic_seq_state_e {LS_IDLE, LS_RUN, LS_DONE}
- idx width is $clog2(WORDS) with a minimum of 1, computed locally.
- No sub-module: slice select is an indexed part-select. The logic unit is instantiated alongside by the parent, not inside.

Test Plan (WORD_WIDTH=8, WORDS=4, bench models the logic unit combinationally):
1. XOR, a=32'hFF00F0F0, b=32'h0FF0FF00 -> rsp_r_o=32'hF0F00FF0, zero=0; rsp_valid_o rises exactly 5 cycles after the accept edge.
2. AND, a=32'h12345678, b=32'hFFFF0000 -> lu_a_o sequence 78,56,34,12 on cycles 1..4; rsp_r_o=32'h12340000.
3. NOTB, b=32'hFFFFFFFF -> lu_not_b_o=00 each RUN cycle; rsp_r_o=0, rsp_zero_o=1; with LOGIC_SEQ_PARITY_EN, rsp_parity_o=0.
4. OR, a=32'h0000000F, b=32'h000000F0, rsp_ready_i low 3 cycles -> rsp_valid_o and rsp_r_o=32'h000000FF held stable; req_ready_o=0 throughout; IDLE 1 cycle after ready.
5. rst_n_i low at cycle 2 of RUN -> next cycle IDLE, rsp_valid_o never asserts, rsp_r_o=0, lu_*=0; new request afterwards completes correctly.
6. Back-to-back requests with rsp_ready_i=1 -> second accepted 6 cycles after the first; req_a_i changed mid-RUN has no effect on the result.
